// File: rtl/lcd1602_responder.sv
// Bus-level HD44780/1602 display model. It samples the controller's bus on
// clk, executes instruction/data writes against a 32-byte DDRAM, answers
// busy/address and data reads, and flags protocol misuse.
module lcd1602_responder #(
    parameter int BUSY_CYCLES  = 50,
    parameter int CLEAR_CYCLES = 100,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   lcd_rs,
    input  logic                   lcd_rw,
    input  logic                   lcd_e,
    input  logic [7:0]             lcd_data_i,
    output logic [7:0]             lcd_data_o,
    output logic                   busy_o,
    output logic [6:0]             cursor_o,
    output logic                   display_on_o,
    output logic                   incr_o,
    input  logic [4:0]             peek_addr_i,
    output logic [7:0]             peek_data_o,
    output logic                   proto_err_o,
    output logic                   addr_err_o,
    output logic [COUNT_WIDTH-1:0] instr_count_o,
    output logic [COUNT_WIDTH-1:0] data_count_o
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_CLEAR} state_t;

    // Clear holds busy for the 32-cycle fill plus the settle time; one
    // down-counter covers both, the fill runs while it is above CLEAR_CYCLES.
    localparam logic [31:0] LP_BUSY    = 32'(BUSY_CYCLES);
    localparam logic [31:0] LP_CLR     = 32'(CLEAR_CYCLES);
    localparam logic [31:0] LP_CLR_TOT = 32'(CLEAR_CYCLES + 32);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   r_e_q;
    logic [31:0]            r_cnt;
    logic [4:0]             r_fill;
    logic [7:0]             r_ddram [32];
    logic [6:0]             r_cursor;
    logic                   r_incr;
    logic                   r_disp;
    logic                   r_proto;
    logic                   r_aerr;
    logic [7:0]             r_dout;
    logic [7:0]             r_peek;
    logic [COUNT_WIDTH-1:0] r_icnt;
    logic [COUNT_WIDTH-1:0] r_dcnt;

    logic       w_fall, w_rise, w_wr, w_rd_data;
    logic       w_acc, w_rej, w_instr, w_dwr, w_is_clear;
    logic       w_busy, w_filling, w_dd_ok;
    logic [4:0] w_cur_idx;
    logic [6:0] w_cur_step;

    // Cursor walk: line 1 is 0x00-0x0F, line 2 is 0x40-0x4F, wrapping between them.
    function automatic logic [6:0] f_step(input logic [6:0] c, input logic inc);
        logic [6:0] n;
        if (inc) begin
            if (c == 7'h0F)      n = 7'h40;
            else if (c == 7'h4F) n = 7'h00;
            else                 n = c + 7'd1;
        end else begin
            if (c == 7'h00)      n = 7'h4F;
            else if (c == 7'h40) n = 7'h0F;
            else                 n = c - 7'd1;
        end
        return n;
    endfunction

    assign w_fall     = r_e_q & ~lcd_e;
    assign w_rise     = ~r_e_q & lcd_e;
    assign w_wr       = w_fall & ~lcd_rw;
    assign w_rd_data  = w_fall & lcd_rw & lcd_rs;
    assign w_busy     = (r_state != S_IDLE);
    assign w_acc      = w_wr & ~w_busy;
    assign w_rej      = w_wr & w_busy;
    assign w_instr    = w_acc & ~lcd_rs;
    assign w_dwr      = w_acc & lcd_rs;
    assign w_is_clear = w_instr & (lcd_data_i == 8'h01);
    assign w_filling  = (r_state == S_CLEAR) && (r_cnt > LP_CLR);
    assign w_dd_ok    = (lcd_data_i[6:4] == 3'b000) || (lcd_data_i[6:4] == 3'b100);
    assign w_cur_idx  = {r_cursor[6], r_cursor[3:0]};
    assign w_cur_step = f_step(r_cursor, r_incr);

    // Edge detector register for the enable strobe.
    always_ff @(posedge clk) begin
        if (!reset) r_e_q <= 1'b0;
        else        r_e_q <= lcd_e;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state: accepted writes start busy; the counter ends busy/clear.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_acc) w_state_nxt = w_is_clear ? S_CLEAR : S_BUSY;
            S_BUSY:  if (r_cnt <= 32'd1) w_state_nxt = S_IDLE;
            S_CLEAR: if (r_cnt <= 32'd1) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Busy/clear duration counter and clear fill pointer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cnt  <= 32'd0;
            r_fill <= 5'd0;
        end else if (w_acc) begin
            r_cnt  <= w_is_clear ? LP_CLR_TOT : LP_BUSY;
            r_fill <= 5'd0;
        end else begin
            if (w_busy && r_cnt != 32'd0) r_cnt <= r_cnt - 32'd1;
            if (w_filling)                r_fill <= r_fill + 5'd1;
        end
    end

    // DDRAM: blanked by reset and by the clear fill, written by data writes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) r_ddram[i] <= 8'h20;
        end else if (w_filling) begin
            r_ddram[r_fill] <= 8'h20;
        end else if (w_dwr) begin
            r_ddram[w_cur_idx] <= lcd_data_i;
        end
    end

    // Instruction decode (highest set bit wins) and cursor movement.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cursor <= 7'h00;
            r_incr   <= 1'b1;
            r_disp   <= 1'b0;
            r_aerr   <= 1'b0;
        end else if (w_instr) begin
            if (lcd_data_i[7]) begin
                if (w_dd_ok) r_cursor <= lcd_data_i[6:0];
                else         r_aerr   <= 1'b1;
            end else if (lcd_data_i[6:4] != 3'b000) begin
                // shift / function set / CGRAM address: no modelled effect
            end else if (lcd_data_i[3]) begin
                r_disp <= lcd_data_i[2];
            end else if (lcd_data_i[2]) begin
                r_incr <= lcd_data_i[1];
            end else if (lcd_data_i[1]) begin
                r_cursor <= 7'h00;
            end else if (lcd_data_i[0]) begin
                r_cursor <= 7'h00;
                r_incr   <= 1'b1;
            end
        end else if (w_dwr || w_rd_data) begin
            r_cursor <= w_cur_step;
        end
    end

    // Sticky protocol error and saturating transaction counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_proto <= 1'b0;
            r_icnt  <= '0;
            r_dcnt  <= '0;
        end else begin
            if (w_rej) r_proto <= 1'b1;
            if (w_instr && r_icnt != '1) r_icnt <= r_icnt + 1'b1;
            if (w_dwr && r_dcnt != '1)   r_dcnt <= r_dcnt + 1'b1;
        end
    end

    // Read data is launched on the rising enable so it is stable by the fall.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_dout <= 8'h00;
        end else if (w_rise && lcd_rw) begin
            r_dout <= lcd_rs ? r_ddram[w_cur_idx] : {w_busy, r_cursor};
        end
    end

    // Registered debug port into DDRAM.
    always_ff @(posedge clk) begin
        if (!reset) r_peek <= 8'h20;
        else        r_peek <= r_ddram[peek_addr_i];
    end

    assign lcd_data_o    = r_dout;
    assign busy_o        = w_busy;
    assign cursor_o      = r_cursor;
    assign display_on_o  = r_disp;
    assign incr_o        = r_incr;
    assign peek_data_o   = r_peek;
    assign proto_err_o   = r_proto;
    assign addr_err_o    = r_aerr;
    assign instr_count_o = r_icnt;
    assign data_count_o  = r_dcnt;

endmodule

// File: tb/tb_lcd1602_responder.sv
// Scoreboard bench for lcd1602_responder: the stimulus pushes expected values
// and expected busy-pulse lengths; one monitor on the falling clock edge pops
// and compares them against the DUT.
module tb_lcd1602_responder;

    localparam int S_BUSY = 0, S_CUR = 1, S_INCR = 2, S_DISP = 3, S_DOUT = 4, S_PEEK = 5;
    localparam int S_PROTO = 6, S_AERR = 7, S_ICNT = 8, S_DCNT = 9, S_BQ = 10;

    typedef struct {
        string       name;
        int          sel;
        logic [15:0] exp;
    } chk_t;

    logic        clk, reset, lcd_rs, lcd_rw, lcd_e;
    logic [7:0]  lcd_data_i, lcd_data_o, peek_data_o;
    logic        busy_o, display_on_o, incr_o, proto_err_o, addr_err_o;
    logic [6:0]  cursor_o;
    logic [4:0]  peek_addr_i;
    logic [15:0] instr_count_o, data_count_o;

    chk_t q_chk[$];
    int   q_busy[$];
    int   checks = 0;
    int   errors = 0;

    chk_t        mon_c;
    logic [15:0] mon_act;
    int          busy_len = 0;
    logic        busy_prev = 1'b0;
    int          exp_len;

    lcd1602_responder dut (
        .clk(clk), .reset(reset), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e),
        .lcd_data_i(lcd_data_i), .lcd_data_o(lcd_data_o), .busy_o(busy_o),
        .cursor_o(cursor_o), .display_on_o(display_on_o), .incr_o(incr_o),
        .peek_addr_i(peek_addr_i), .peek_data_o(peek_data_o),
        .proto_err_o(proto_err_o), .addr_err_o(addr_err_o),
        .instr_count_o(instr_count_o), .data_count_o(data_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] get_act(input int sel);
        case (sel)
            S_BUSY:  return {15'd0, busy_o};
            S_CUR:   return {9'd0, cursor_o};
            S_INCR:  return {15'd0, incr_o};
            S_DISP:  return {15'd0, display_on_o};
            S_DOUT:  return {8'd0, lcd_data_o};
            S_PEEK:  return {8'd0, peek_data_o};
            S_PROTO: return {15'd0, proto_err_o};
            S_AERR:  return {15'd0, addr_err_o};
            S_ICNT:  return instr_count_o;
            S_DCNT:  return data_count_o;
            S_BQ:    return 16'(q_busy.size());
            default: return 16'hDEAD;
        endcase
    endfunction

    // Monitor: drain value checks, and measure each busy pulse against the
    // next expected length (pulses cut short by reset are dropped).
    always @(negedge clk) begin
        while (q_chk.size() > 0) begin
            mon_c   = q_chk.pop_front();
            mon_act = get_act(mon_c.sel);
            checks++;
            if (mon_act !== mon_c.exp) begin
                errors++;
                $display("FAIL %s actual=%h expected=%h", mon_c.name, mon_act, mon_c.exp);
            end
        end
        if (!reset) begin
            busy_len  = 0;
            busy_prev = 1'b0;
        end else begin
            if (busy_o === 1'b1) begin
                busy_len++;
            end else if (busy_prev) begin
                checks++;
                if (q_busy.size() == 0) begin
                    errors++;
                    $display("FAIL busy_unexpected actual=%0d required=none", busy_len);
                end else begin
                    exp_len = q_busy.pop_front();
                    if (busy_len != exp_len) begin
                        errors++;
                        $display("FAIL busy_len actual=%0d required=%0d", busy_len, exp_len);
                    end
                end
                busy_len = 0;
            end
            busy_prev = (busy_o === 1'b1);
        end
    end

    task automatic chk(input string n, input int sel, input logic [15:0] e);
        chk_t c;
        c.name = n; c.sel = sel; c.exp = e;
        q_chk.push_back(c);
    endtask

    // Let the monitor consume pending checks, return at posedge+1.
    task automatic flush();
        @(negedge clk); #1;
        @(posedge clk); #1;
    endtask

    // One enable pulse: rise, then fall; returns just after the fall is processed.
    task automatic bus_op(input logic rs, input logic rw, input logic [7:0] d);
        lcd_rs = rs; lcd_rw = rw; lcd_data_i = d; lcd_e = 1'b1;
        @(posedge clk); #1;
        lcd_e = 1'b0;
        @(posedge clk); #1;
        lcd_rw = 1'b0;
    endtask

    task automatic wr(input logic rs, input logic [7:0] d, input int busy_len_exp);
        q_busy.push_back(busy_len_exp);
        bus_op(rs, 1'b0, d);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_o !== 1'b0 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_reached", S_BUSY, 16'd0);
        flush();
    endtask

    task automatic peek(input logic [4:0] idx, input logic [7:0] e, input string n);
        peek_addr_i = idx;
        @(posedge clk); #1;
        chk(n, S_PEEK, {8'd0, e});
        flush();
    endtask

    task automatic reset_checks();
        chk("rst_busy", S_BUSY, 16'd0);
        chk("rst_cursor", S_CUR, 16'h00);
        chk("rst_incr", S_INCR, 16'd1);
        chk("rst_disp", S_DISP, 16'd0);
        chk("rst_dout", S_DOUT, 16'h00);
        chk("rst_peek", S_PEEK, 16'h20);
        chk("rst_proto", S_PROTO, 16'd0);
        chk("rst_aerr", S_AERR, 16'd0);
        chk("rst_icnt", S_ICNT, 16'd0);
        chk("rst_dcnt", S_DCNT, 16'd0);
        flush();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_e = 1'b0;
        lcd_data_i = 8'h00; peek_addr_i = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        reset_checks();
        reset = 1'b1;
        @(posedge clk); #1;

        // Set DDRAM address 0, read busy/address while busy, then write 'A'.
        wr(1'b0, 8'h80, 50);
        bus_op(1'b0, 1'b1, 8'h00);
        chk("rd_busy_addr", S_DOUT, 16'h80);
        chk("busy_during_rd", S_BUSY, 16'd1);
        chk("rd_no_proto", S_PROTO, 16'd0);
        flush();
        wait_idle();
        wr(1'b1, 8'h41, 50);
        wait_idle();
        peek(5'd0, 8'h41, "peek0_A");
        chk("cur_after_A", S_CUR, 16'h01);
        chk("dcnt_1", S_DCNT, 16'd1);
        chk("icnt_1", S_ICNT, 16'd1);
        flush();

        // Accepted write then a write during busy: only the first takes effect.
        wr(1'b1, 8'h42, 50);
        bus_op(1'b1, 1'b0, 8'h99);
        wait_idle();
        chk("proto_set", S_PROTO, 16'd1);
        chk("cur_unchanged", S_CUR, 16'h02);
        chk("dcnt_unchanged", S_DCNT, 16'd2);
        flush();
        peek(5'd1, 8'h42, "peek1_B");
        peek(5'd2, 8'h20, "peek2_untouched");

        // Line 2 fill, ending with the 0x4F -> 0x00 wrap.
        wr(1'b0, 8'hC0, 50);
        wait_idle();
        for (int i = 0; i < 16; i++) begin
            wr(1'b1, 8'(8'h30 + i), 50);
            wait_idle();
        end
        peek(5'd16, 8'h30, "peek16");
        peek(5'd23, 8'h37, "peek23");
        peek(5'd31, 8'h3F, "peek31");
        chk("cur_wrap", S_CUR, 16'h00);
        chk("dcnt_18", S_DCNT, 16'd18);
        chk("icnt_2", S_ICNT, 16'd2);
        flush();

        // Data read returns DDRAM[cursor] and steps the cursor, no busy.
        bus_op(1'b1, 1'b1, 8'h00);
        chk("rd_data", S_DOUT, 16'h41);
        chk("rd_step", S_CUR, 16'h01);
        chk("rd_not_busy", S_BUSY, 16'd0);
        flush();

        // Decrement mode across the 0x40 -> 0x0F boundary, then bad address.
        wr(1'b0, 8'h04, 50);
        wait_idle();
        wr(1'b0, 8'hC0, 50);
        wait_idle();
        wr(1'b1, 8'h55, 50);
        wait_idle();
        peek(5'd16, 8'h55, "peek16_dec");
        chk("incr_0", S_INCR, 16'd0);
        chk("cur_dec_wrap", S_CUR, 16'h0F);
        flush();
        wr(1'b0, 8'h90, 50);
        wait_idle();
        chk("aerr_set", S_AERR, 16'd1);
        chk("cur_kept", S_CUR, 16'h0F);
        flush();
        wr(1'b0, 8'h0C, 50);
        wait_idle();
        chk("disp_on", S_DISP, 16'd1);
        chk("icnt_6", S_ICNT, 16'd6);
        chk("dcnt_19", S_DCNT, 16'd19);
        flush();

        // Clear: 32 fill + 100 settle cycles of busy.
        wr(1'b0, 8'h01, 132);
        wait_idle();
        peek(5'd0, 8'h20, "clr_peek0");
        peek(5'd16, 8'h20, "clr_peek16");
        peek(5'd31, 8'h20, "clr_peek31");
        chk("clr_cur", S_CUR, 16'h00);
        chk("clr_incr", S_INCR, 16'd1);
        chk("clr_disp_kept", S_DISP, 16'd1);
        chk("icnt_7", S_ICNT, 16'd7);
        flush();

        // Reset in the middle of a clear aborts it.
        peek_addr_i = 5'd1;
        bus_op(1'b0, 1'b0, 8'h01);
        repeat (40) @(posedge clk);
        #1;
        chk("clear_in_progress", S_BUSY, 16'd1);
        flush();
        reset = 1'b0;
        @(posedge clk); #1;
        reset_checks();
        reset = 1'b1;
        @(posedge clk); #1;
        chk("busy_q_drained", S_BQ, 16'd0);
        flush();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
